// File: rtl/serial_adder_ctrl.sv
// Bit-serial sequencer driving one external 1-bit full adder, LSB first.
// Optional subtract mode is compiled in when SERIAL_SUB_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_nxt;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   b_load;
    logic               cin_load;

    // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
    always_comb begin
`ifdef SERIAL_SUB_EN
        b_load   = sub ? ~b : b;
        cin_load = sub;
`else
        b_load   = b;
        cin_load = 1'b0;
`endif
    end

    // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        sum_nxt            = sum_sh >> 1;
        sum_nxt[WIDTH-1]   = fa_sum;
    end

    assign fa_a   = (state == RUN) & a_sh[0];
    assign fa_b   = (state == RUN) & b_sh[0];
    assign fa_cin = (state == RUN) & carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        a_sh    <= a;
                        b_sh    <= b_load;
                        carry_q <= cin_load;
                        cnt     <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh  <= sum_nxt;
                    carry_q <= fa_cout;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    // Last bit: publish the result, sum/cout stay put until the next finish.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= sum_nxt;
                        cout  <= fa_cout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=2 and WIDTH=4 instances, each with its own full adder.
// Subtract vectors run only when SERIAL_SUB_EN is defined.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2, fa_a2, fa_b2, fa_cin2, fa_sum2, fa_cout2;
    logic [1:0] sum2;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       sub4 = 1'b0;
    logic       busy4, done4, cout4, fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4;
    logic [3:0] sum4;

    assign fa_sum2  = fa_a2 ^ fa_b2 ^ fa_cin2;
    assign fa_cout2 = (fa_a2 & fa_b2) | (fa_a2 & fa_cin2) | (fa_b2 & fa_cin2);
    assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2),
        .fa_sum(fa_sum2), .fa_cout(fa_cout2)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
`ifdef SERIAL_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4),
        .fa_sum(fa_sum4), .fa_cout(fa_cout4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: operands, bits consumed so far, and the published result.
    typedef struct {
        int w;
        bit busy;
        bit done;
        bit cout;
        int sum;
        int idx;
        int opa;
        int opb;
        bit cin0;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, int w, bit r, bit st, int a, int b, bit sb);
        mdl_t n = m;
        int tot;
        n.w = w;
        if (r) begin
            n.busy = 0; n.done = 0; n.cout = 0; n.sum = 0;
            n.idx = 0; n.opa = 0; n.opb = 0; n.cin0 = 0;
        end else if (m.busy) begin
            n.idx  = m.idx + 1;
            n.done = 0;
            if (n.idx == w) begin
                n.busy = 0;
                n.done = 1;
                tot    = m.opa + m.opb + int'(m.cin0);
                n.sum  = tot % (1 << w);
                n.cout = ((tot >> w) & 1) != 0;
            end
        end else begin
            n.done = 0;
            if (st) begin
                n.busy = 1;
                n.idx  = 0;
                n.opa  = a;
                n.opb  = sb ? (~b) & ((1 << w) - 1) : b;
                n.cin0 = sb;
            end
        end
        return n;
    endfunction

    // Expected {busy,done,cout,fa_a,fa_b,fa_cin,sum[15:0]}.
    function automatic logic [31:0] mexp(mdl_t m);
        logic fa, fb, fc;
        int   msk;
        fa = 0; fb = 0; fc = 0;
        if (m.busy) begin
            msk = (1 << m.idx) - 1;
            fa  = ((m.opa >> m.idx) & 1) != 0;
            fb  = ((m.opb >> m.idx) & 1) != 0;
            fc  = (((((m.opa & msk) + (m.opb & msk) + int'(m.cin0)) >> m.idx)) & 1) != 0;
        end
        return {10'b0, m.busy, m.done, m.cout, fa, fb, fc, 16'(m.sum)};
    endfunction

    mdl_t m2, m4;

    always @(posedge clk) begin
        m2 <= mstep(m2, 2, rst, start2, int'(a2), int'(b2), 1'b0);
        m4 <= mstep(m4, 4, rst, start4, int'(a4), int'(b4), sub4);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_w2", {10'b0, busy2, done2, cout2, fa_a2, fa_b2, fa_cin2, 14'b0, sum2}, mexp(m2));
            check("cycle_w4", {10'b0, busy4, done4, cout4, fa_a4, fa_b4, fa_cin4, 12'b0, sum4}, mexp(m4));
        end
    end

    task automatic wait_done4(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                got = 1'b1;
                return;
            end
        end
        check("done4_timeout", 32'd0, 32'd1);
    endtask

    task automatic run4(input int a, input int b, input bit sb, input int es, input int ec, input string nm);
        bit got;
        @(negedge clk);
        a4 = 4'(a); b4 = 4'(b); sub4 = sb; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(got);
        check({nm, "_sum"}, 32'(sum4), 32'(es));
        check({nm, "_cout"}, 32'(cout4), 32'(ec));
    endtask

    int vec_a[5] = '{0, 15, 8, 10, 6};
    int vec_b[5] = '{0, 15, 8, 5, 3};
    int vec_s[5] = '{0, 14, 0, 15, 9};
    int vec_c[5] = '{0, 1, 1, 0, 0};

    initial begin
        int first, second, ndone, dsum, dcout;

        // Reset for two cycles.
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_sum_cout", {29'b0, cout2, sum2}, 32'd0);
        check("rst_fa", {29'b0, fa_a2, fa_b2, fa_cin2}, 32'd0);
        rst = 1'b0;

        // 3 + 3 on WIDTH=2: busy two cycles, done at k+3.
        @(negedge clk);
        a2 = 2'd3; b2 = 2'd3; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("t2_busy1", 32'(busy2), 32'd1);
        @(negedge clk);
        check("t2_busy2", 32'(busy2), 32'd1);
        @(negedge clk);
        check("t2_done", {30'b0, busy2, done2}, 32'd1);
        check("t2_sum", 32'(sum2), 32'd2);
        check("t2_cout", 32'(cout2), 32'd1);
        check("t2_model_sum", 32'(m2.sum), 32'd2);
        @(negedge clk);
        check("t2_done_low", 32'(done2), 32'd0);
        check("t2_sum_held", 32'(sum2), 32'd2);

        // 1 + 2 with start held six cycles: back-to-back runs, done pulses 3 apart.
        a2 = 2'd1; b2 = 2'd2; start2 = 1'b1;
        first = 0; second = 0; ndone = 0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                ndone++;
                if (first == 0) first = j; else second = j;
                check("t3_sum", {29'b0, cout2, sum2}, 32'd3);
            end
            if (j == 6) start2 = 1'b0;
        end
        check("t3_ndone", 32'(ndone), 32'd2);
        check("t3_first", 32'(first), 32'd3);
        check("t3_gap", 32'(second - first), 32'd3);

        // 9 + 8 on WIDTH=4 with operand change and start pulse during RUN.
        a4 = 4'd9; b4 = 4'd8; start4 = 1'b1;
        ndone = 0; first = 0; dsum = -1; dcout = -1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 1) begin start4 = 1'b0; a4 = 4'd0; end
            if (j == 2) start4 = 1'b1;
            if (j == 3) start4 = 1'b0;
            if (done4 === 1'b1) begin
                ndone++; first = j; dsum = int'(sum4); dcout = int'(cout4);
            end
        end
        check("t4_ndone", 32'(ndone), 32'd1);
        check("t4_when", 32'(first), 32'd5);
        check("t4_sum", 32'(dsum), 32'd1);
        check("t4_cout", 32'(dcout), 32'd1);
        check("t4_model_cout", 32'(m4.cout), 32'd1);

        // Directed WIDTH=4 vectors including all-ones and carry-out with zero sum.
        for (int v = 0; v < 5; v++)
            run4(vec_a[v], vec_b[v], 1'b0, vec_s[v], vec_c[v], "vec");

        // Reset two cycles into a 15 + 1 run; the start seen during reset is lost.
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1; start4 = 1'b1; a4 = 4'd5; b4 = 4'd6;
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0;
        check("t5_rst_outs", {26'b0, busy4, done4, cout4, fa_a4, fa_b4, fa_cin4}, 32'd0);
        check("t5_rst_sum", 32'(sum4), 32'd0);
        @(negedge clk);
        check("t5_start_lost", 32'(busy4), 32'd0);
        run4(5, 6, 1'b0, 11, 0, "t5");

`ifdef SERIAL_SUB_EN
        run4(5, 7, 1'b1, 14, 0, "sub_borrow");
        run4(7, 5, 1'b1, 2, 1, "sub_noborrow");
        run4(7, 5, 1'b0, 12, 0, "sub_off");
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
